// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the one-hot serial pattern detector.
package seq_detect_pkg;

    // Legal pattern lengths; the one-hot state is one bit wider than the pattern.
    localparam int PAT_W_MIN   = 2;
    localparam int PAT_W_MAX   = 16;
    localparam int STATE_W_MAX = PAT_W_MAX + 1;

    // Index of the set bit of a one-hot vector (highest set bit wins, 0 if none).
    function automatic int onehot_idx(input logic [STATE_W_MAX-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < STATE_W_MAX; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/seq_detect_onehot_if.sv
// Port bundle of the serial pattern detector.
//
// Handshake: in_valid qualifies in_bit on a rising clk edge. There is no
// ready; the detector accepts every valid bit (no backpressure). cfg_load
// takes priority and discards the bit presented in the same cycle.
interface seq_detect_onehot_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_bit;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
    logic             clr_count;
    logic [PAT_W:0]   state;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             state_err;

    // Stimulus/controller side.
    modport master (
        output in_valid, in_bit, cfg_load, cfg_pattern, cfg_overlap, clr_count,
        input  state, match, match_count, state_err
    );

    // Detector side.
    modport slave (
        input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_overlap, clr_count,
        output state, match, match_count, state_err
    );
endinterface

// File: rtl/seq_detect_next.sv
// Next-state decode: parallel compare of every pattern prefix against the
// newest bits, picking the longest prefix that is reachable from the current
// state. Only suffixes up to (current length + 1) can be genuine, so stale
// history bits never produce a false hit.
module seq_detect_next
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 3
) (
    input  logic [PAT_W:0]   state,
    input  logic [PAT_W-1:0] history,
    input  logic             in_bit,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic [PAT_W:0]   next_state
);

    logic [PAT_W-1:0] cand;
    logic [PAT_W-1:0] pfx;
    logic [PAT_W-1:0] mask;
    logic             unused_hist_msb;
    int               cur_len;
    int               best;

    // The oldest history bit drops out of the window once the new bit arrives.
    assign cand            = {history[PAT_W-2:0], in_bit};
    assign unused_hist_msb = history[PAT_W-1];

    // Prefix compare for k=1..PAT_W; highest reachable hit selects the state.
    always_comb begin
        cur_len = onehot_idx((STATE_W_MAX)'(state));
        // Non-overlapping: a completed match restarts from an empty history.
        if (cur_len == PAT_W && !overlap) cur_len = 0;
        best = 0;
        pfx  = '0;
        mask = '0;
        for (int j = 1; j <= PAT_W; j++) begin
            pfx  = pattern >> (PAT_W - j);
            mask = '1;
            mask = mask >> (PAT_W - j);
            if ((((cand ^ pfx) & mask) == '0) && (j <= cur_len + 1)) best = j;
        end
        next_state = (PAT_W + 1)'(1) << best;
    end

endmodule

// File: rtl/seq_detect_onehot.sv
// Serial pattern detector with a one-hot Moore FSM, saturating match counter
// and one-hot integrity check. Holds only the registers; decode lives in
// seq_detect_next.
module seq_detect_onehot
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               aresetn,
    seq_detect_onehot_if.slave bus
);

    localparam int ST_W = PAT_W + 1;

    logic [PAT_W-1:0] pat_q;
    logic             ovl_q;
    logic [PAT_W-1:0] hist_q;
    logic [ST_W-1:0]  state_q;
    logic [ST_W-1:0]  state_d;
    logic [ST_W-1:0]  dec_state;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             accept;
    logic             bad_state;
    logic             inc;

    assign accept    = bus.in_valid && !bus.cfg_load;
    assign bad_state = !$onehot(state_q);
    assign inc       = accept && !bad_state && dec_state[PAT_W];

    seq_detect_next #(.PAT_W(PAT_W)) u_next (
        .state      (state_q),
        .history    (hist_q),
        .in_bit     (bus.in_bit),
        .pattern    (pat_q),
        .overlap    (ovl_q),
        .next_state (dec_state)
    );

    // Configuration capture; overlap defaults on after reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pat_q <= '0;
            ovl_q <= 1'b1;
        end else if (bus.cfg_load) begin
            pat_q <= bus.cfg_pattern;
            ovl_q <= bus.cfg_overlap;
        end
    end

    // History shift register of accepted bits, cleared on reconfiguration.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            hist_q <= '0;
        end else if (bus.cfg_load) begin
            hist_q <= '0;
        end else if (accept) begin
            hist_q <= {hist_q[PAT_W-2:0], bus.in_bit};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_W'(1);
        else          state_q <= state_d;
    end

    // FSM next state: corrupt state recovers to S_0 ahead of everything else.
    always_comb begin
        state_d = state_q;
        if (bad_state)         state_d = ST_W'(1);
        else if (bus.cfg_load) state_d = ST_W'(1);
        else if (accept)       state_d = dec_state;
    end

    // Saturating match counter; a clear that coincides with a match leaves 1.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else if (bus.clr_count) begin
            cnt_q <= inc ? CNT_W'(1) : '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Error flag: high for the cycle in which a bad state is being corrected.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) err_q <= 1'b0;
        else          err_q <= bad_state;
    end

    // FSM outputs (Moore).
    always_comb begin
        bus.state       = state_q;
        bus.match       = state_q[PAT_W];
        bus.match_count = cnt_q;
        bus.state_err   = err_q;
    end

endmodule

// File: tb/tb_seq_detect_onehot.sv
// Directed bench for seq_detect_onehot: one PAT_W=3/CNT_W=8 instance for the
// detection behaviour and one PAT_W=2/CNT_W=2 instance for counter saturation.
module tb_seq_detect_onehot;

    logic clk = 1'b0;
    logic aresetn;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] exp_q[$];

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    seq_detect_onehot_if #(.PAT_W(3), .CNT_W(8)) bus ();
    seq_detect_onehot_if #(.PAT_W(2), .CNT_W(2)) bus2 ();

    seq_detect_onehot #(.PAT_W(3), .CNT_W(8)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    seq_detect_onehot #(.PAT_W(2), .CNT_W(2)) dut2 (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus2)
    );

    // Checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drivers (all start and end on a falling edge)
    task automatic idle_inputs();
        bus.in_valid = 0;  bus.in_bit = 0;  bus.cfg_load = 0;
        bus.cfg_pattern = '0;  bus.cfg_overlap = 0;  bus.clr_count = 0;
        bus2.in_valid = 0; bus2.in_bit = 0; bus2.cfg_load = 0;
        bus2.cfg_pattern = '0; bus2.cfg_overlap = 0; bus2.clr_count = 0;
    endtask

    task automatic send_bit(input logic b);
        bus.in_valid = 1; bus.in_bit = b;
        @(posedge clk); #1;
        bus.in_valid = 0; bus.in_bit = 0;
        @(negedge clk);
    endtask

    task automatic load_cfg(input logic [2:0] pat, input logic ovl);
        bus.cfg_load = 1; bus.cfg_pattern = pat; bus.cfg_overlap = ovl;
        @(posedge clk); #1;
        bus.cfg_load = 0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        bus.clr_count = 1;
        @(posedge clk); #1;
        bus.clr_count = 0;
        @(negedge clk);
    endtask

    task automatic send_bit2(input logic b);
        bus2.in_valid = 1; bus2.in_bit = b;
        @(posedge clk); #1;
        bus2.in_valid = 0; bus2.in_bit = 0;
        @(negedge clk);
    endtask

    // Scoreboard: each accepted bit pops one expected one-hot state.
    task automatic run_stream(input string tag, input logic [15:0] bits, input int n);
        logic [31:0] e;
        for (int i = 0; i < n; i++) begin
            send_bit(bits[n-1-i]);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hffff_ffff;
            check($sformatf("%s_state[%0d]", tag, i), 32'(bus.state), e);
            check($sformatf("%s_match[%0d]", tag, i), 32'(bus.match), 32'(e[3]));
        end
    endtask

    // Main sequence
    initial begin
        idle_inputs();
        aresetn = 0;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(bus.state), 32'h1);
        check("rst_match", 32'(bus.match), 32'h0);
        check("rst_count", 32'(bus.match_count), 32'h0);
        check("rst_err",   32'(bus.state_err), 32'h0);
        check("rst_state2", 32'(bus2.state), 32'h1);
        aresetn = 1;

        // Reset pattern is 000 with overlap on; first edge accepts input.
        exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(8); exp_q.push_back(8);
        run_stream("post_rst", 16'b0000, 4);
        check("post_rst_count", 32'(bus.match_count), 2);

        // Pattern 101 overlapping
        load_cfg(3'b101, 1'b1);
        check("load_state", 32'(bus.state), 32'h1);
        check("load_count_kept", 32'(bus.match_count), 2);
        pulse_clr();
        check("clr_count", 32'(bus.match_count), 0);
        exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(8);
        exp_q.push_back(4); exp_q.push_back(8);
        run_stream("ovl101", 16'b10101, 5);
        check("ovl101_count", 32'(bus.match_count), 2);

        // Pattern 101 non-overlapping, stream 1010101
        load_cfg(3'b101, 1'b0);
        pulse_clr();
        exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(8); exp_q.push_back(1);
        exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(8);
        run_stream("novl101", 16'b1010101, 7);
        check("novl101_count", 32'(bus.match_count), 2);

        // in_valid low: everything holds even with in_bit toggling
        bus.in_bit = 1;
        repeat (3) @(negedge clk);
        bus.in_bit = 0;
        check("hold_state", 32'(bus.state), 32'h8);
        check("hold_match", 32'(bus.match), 32'h1);
        check("hold_count", 32'(bus.match_count), 2);

        // Pattern 111 overlapping then non-overlapping
        load_cfg(3'b111, 1'b1);
        pulse_clr();
        exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(8);
        exp_q.push_back(8); exp_q.push_back(8);
        run_stream("ovl111", 16'b11111, 5);
        check("ovl111_count", 32'(bus.match_count), 3);
        load_cfg(3'b111, 1'b0);
        pulse_clr();
        exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(8);
        exp_q.push_back(2); exp_q.push_back(4);
        run_stream("novl111", 16'b11111, 5);
        check("novl111_count", 32'(bus.match_count), 1);

        // Reconfigure from S_2; the bit presented with cfg_load is ignored
        load_cfg(3'b101, 1'b1);
        exp_q.push_back(2); exp_q.push_back(4);
        run_stream("pre_cfg", 16'b10, 2);
        bus.in_valid = 1; bus.in_bit = 1;
        load_cfg(3'b110, 1'b1);
        bus.in_valid = 0; bus.in_bit = 0;
        check("cfg_state", 32'(bus.state), 32'h1);
        check("cfg_count", 32'(bus.match_count), 1);
        exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(8);
        exp_q.push_back(2); exp_q.push_back(4);
        run_stream("pat110", 16'b11011, 5);
        check("pat110_count", 32'(bus.match_count), 2);

        // Asynchronous reset mid-stream (sitting in S_2)
        aresetn = 0;
        #1;
        check("async_rst_state", 32'(bus.state), 32'h1);
        check("async_rst_count", 32'(bus.match_count), 0);
        @(negedge clk);
        aresetn = 1;
        load_cfg(3'b110, 1'b1);
        exp_q.push_back(1);
        run_stream("span_rst", 16'b0, 1);
        check("span_rst_count", 32'(bus.match_count), 0);

        // Corrupt state recovers to S_0 even with a valid bit present
        force dut.state_q = 4'b0110;
        #1;
        release dut.state_q;
        bus.in_valid = 1; bus.in_bit = 1;
        @(posedge clk); #1;
        bus.in_valid = 0; bus.in_bit = 0;
        check("bad_state_recover", 32'(bus.state), 32'h1);
        check("bad_state_err", 32'(bus.state_err), 32'h1);
        @(posedge clk); #1;
        check("bad_state_err_clear", 32'(bus.state_err), 32'h0);
        check("bad_state_hold", 32'(bus.state), 32'h1);
        @(negedge clk);

        // Counter saturation on the 2-bit counter instance, pattern 11
        bus2.cfg_load = 1; bus2.cfg_pattern = 2'b11; bus2.cfg_overlap = 1;
        @(posedge clk); #1;
        bus2.cfg_load = 0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            send_bit2(1'b1);
            if (i == 2) check("sat_count_mid", 32'(bus2.match_count), 2);
        end
        check("sat_count", 32'(bus2.match_count), 3);
        check("sat_state", 32'(bus2.state), 32'h4);
        bus2.clr_count = 1;
        send_bit2(1'b1);
        bus2.clr_count = 0;
        check("clr_with_match", 32'(bus2.match_count), 1);
        bus2.clr_count = 1;
        @(posedge clk); #1;
        bus2.clr_count = 0;
        @(negedge clk);
        check("clr_alone", 32'(bus2.match_count), 0);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
